lut_bitserial_ctrl: RTL

- Sequencer for one LUT-based bit-serial PE (8-entry, 16b-per-entry lookup table feeding 12 output rows).
- Accepts a job: 3 activations, a weight precision, and a stream of weight bit-planes.
- Builds and loads the 8 table entries, then streams bit-planes into the LUT datapath LSB-first.
- Shift-accumulates the 12 returned partial sums into full-width signed results, presented on a valid/ready output.

---
 rtl/lut_bitserial_ctrl_if.sv | 47 ++++
 rtl/lut_bitserial_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/lut_bitserial_ctrl_if.sv
// Job, bit-plane, LUT-datapath and result signals of the LUT bit-serial sequencer.
//   master : job source, bit-plane source, LUT datapath and result sink
//   slave  : lut_bitserial_ctrl
// Signals:
//   start_valid/start_ready, act, wbits       job request
//   wplane_valid/wplane_ready, wplane         weight bit-plane stream
//   lut_mode, lut_table_update,
//   lut_update_values, lut_weights,
//   lut_weights_1b, partial_sums              LUT datapath
//   acc_out, out_valid/out_ready              result
interface lut_bitserial_ctrl_if #(
    parameter int unsigned WEIGHT_WIDTH = 12,
    parameter int unsigned ACT_WIDTH    = 8,
    parameter int unsigned ACC_WIDTH    = 32
);
    localparam int unsigned PS_WIDTH    = 16;
    localparam int unsigned TABLE_WIDTH = 128;

    logic                              start_valid;
    logic                              start_ready;
    logic [3*ACT_WIDTH-1:0]            act;
    logic [4:0]                        wbits;
    logic                              wplane_valid;
    logic                              wplane_ready;
    logic [3*WEIGHT_WIDTH-1:0]         wplane;
    logic                              lut_mode;
    logic                              lut_table_update;
    logic [TABLE_WIDTH-1:0]            lut_update_values;
    logic [3*WEIGHT_WIDTH-1:0]         lut_weights;
    logic [WEIGHT_WIDTH:0]             lut_weights_1b;
    logic [WEIGHT_WIDTH*PS_WIDTH-1:0]  partial_sums;
    logic [WEIGHT_WIDTH*ACC_WIDTH-1:0] acc_out;
    logic                              out_valid;
    logic                              out_ready;

    modport master (
        output start_valid, act, wbits, wplane_valid, wplane, partial_sums, out_ready,
        input  start_ready, wplane_ready, lut_mode, lut_table_update, lut_update_values,
               lut_weights, lut_weights_1b, acc_out, out_valid
    );

    modport slave (
        input  start_valid, act, wbits, wplane_valid, wplane, partial_sums, out_ready,
        output start_ready, wplane_ready, lut_mode, lut_table_update, lut_update_values,
               lut_weights, lut_weights_1b, acc_out, out_valid
    );
endinterface

// File: rtl/lut_bitserial_ctrl.sv
// Sequencer for one LUT-based bit-serial PE: builds the 8-entry activation
// table, streams weight bit-planes LSB-first into the LUT and shift-accumulates
// the returned per-row partial sums into signed results.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  lut_bitserial_ctrl_if.slave (job, plane, LUT and result signals)
module lut_bitserial_ctrl #(
    parameter int unsigned WEIGHT_WIDTH = 12,
    parameter int unsigned ACT_WIDTH    = 8,
    parameter int unsigned ACC_WIDTH    = 32
) (
    input logic                 clk,
    input logic                 rst,
    lut_bitserial_ctrl_if.slave bus
);
    localparam int unsigned ENTRY_WIDTH   = 16;
    localparam int unsigned PS_WIDTH      = 16;
    localparam int unsigned N_ENTRIES     = 8;
    localparam int unsigned N_ACTS        = 3;
    localparam int unsigned CNT_WIDTH     = 5;
    localparam int unsigned SHIFT_WIDTH   = 4;
    localparam int unsigned MAX_WBITS     = 16;
    localparam int unsigned PLANE_WIDTH   = N_ACTS * WEIGHT_WIDTH;
    localparam int unsigned TABLE_WIDTH   = N_ENTRIES * ENTRY_WIDTH;
    localparam int unsigned ACC_BUS_WIDTH = WEIGHT_WIDTH * ACC_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_OUT} state_e;

    state_e                   state_q, state_d;
    logic [CNT_WIDTH-1:0]     wbits_q, wbits_d;
    logic                     mode_q, mode_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic                     pend_q, pend_d;
    logic [SHIFT_WIDTH-1:0]   shift_q, shift_d;
    logic                     neg_q, neg_d;
    logic [PLANE_WIDTH-1:0]   lut_weights_q, lut_weights_d;
    logic                     table_update_q, table_update_d;
    logic [TABLE_WIDTH-1:0]   table_q, table_d;
    logic [ACC_BUS_WIDTH-1:0] acc_q, acc_d;
    logic                     start_ready_q, start_ready_d;
    logic                     wplane_ready_q, wplane_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic [WEIGHT_WIDTH:0]    ones_q;

    logic                     start_fire, plane_fire, out_fire;
    logic [CNT_WIDTH-1:0]     wbits_eff;
    logic [ACC_WIDTH-1:0]     ps_ext, term;

    // Entry k selects a_j where bit j of k is set; binary mode subtracts the rest.
    function automatic logic [TABLE_WIDTH-1:0] build_table(
        input logic [N_ACTS*ACT_WIDTH-1:0] act,
        input logic                        binary
    );
        logic [TABLE_WIDTH-1:0] tbl;
        logic [ENTRY_WIDTH-1:0] entry;
        logic [ENTRY_WIDTH-1:0] a_ext;
        tbl = '0;
        for (int unsigned k = 0; k < N_ENTRIES; k++) begin
            entry = '0;
            for (int unsigned j = 0; j < N_ACTS; j++) begin
                a_ext = ENTRY_WIDTH'($signed(act[j*ACT_WIDTH +: ACT_WIDTH]));
                if (k[j]) begin
                    entry = entry + a_ext;
                end else if (binary) begin
                    entry = entry - a_ext;
                end
            end
            tbl[k*ENTRY_WIDTH +: ENTRY_WIDTH] = entry;
        end
        return tbl;
    endfunction

    assign start_fire = start_ready_q && bus.start_valid;
    assign plane_fire = wplane_ready_q && bus.wplane_valid;
    assign out_fire   = out_valid_q && bus.out_ready;

    // Precision 0 means binary; anything beyond the table's reach saturates.
    assign wbits_eff = (bus.wbits == '0)                      ? CNT_WIDTH'(1) :
                       (bus.wbits > CNT_WIDTH'(MAX_WBITS))     ? CNT_WIDTH'(MAX_WBITS) :
                                                                 bus.wbits;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            wbits_q        <= '0;
            mode_q         <= 1'b0;
            cnt_q          <= '0;
            pend_q         <= 1'b0;
            shift_q        <= '0;
            neg_q          <= 1'b0;
            lut_weights_q  <= '0;
            table_update_q <= 1'b0;
            table_q        <= '0;
            acc_q          <= '0;
            start_ready_q  <= 1'b1;
            wplane_ready_q <= 1'b0;
            out_valid_q    <= 1'b0;
            ones_q         <= '0;
        end else begin
            state_q        <= state_d;
            wbits_q        <= wbits_d;
            mode_q         <= mode_d;
            cnt_q          <= cnt_d;
            pend_q         <= pend_d;
            shift_q        <= shift_d;
            neg_q          <= neg_d;
            lut_weights_q  <= lut_weights_d;
            table_update_q <= table_update_d;
            table_q        <= table_d;
            acc_q          <= acc_d;
            start_ready_q  <= start_ready_d;
            wplane_ready_q <= wplane_ready_d;
            out_valid_q    <= out_valid_d;
            ones_q         <= '1;
        end
    end

    // Next-state, accumulation and registered-output decode.
    always_comb begin
        state_d        = state_q;
        wbits_d        = wbits_q;
        mode_d         = mode_q;
        cnt_d          = cnt_q;
        pend_d         = 1'b0;
        shift_d        = shift_q;
        neg_d          = neg_q;
        lut_weights_d  = lut_weights_q;
        table_update_d = 1'b0;
        table_d        = table_q;
        acc_d          = acc_q;
        ps_ext         = '0;
        term           = '0;

        // Fold in the plane presented to the LUT during this cycle.
        if (pend_q) begin
            for (int unsigned i = 0; i < WEIGHT_WIDTH; i++) begin
                ps_ext = ACC_WIDTH'($signed(bus.partial_sums[i*PS_WIDTH +: PS_WIDTH]));
                term   = ps_ext << shift_q;
                acc_d[i*ACC_WIDTH +: ACC_WIDTH] = neg_q ? acc_q[i*ACC_WIDTH +: ACC_WIDTH] - term
                                                        : acc_q[i*ACC_WIDTH +: ACC_WIDTH] + term;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (start_fire) begin
                    wbits_d        = wbits_eff;
                    mode_d         = (wbits_eff == CNT_WIDTH'(1));
                    cnt_d          = '0;
                    acc_d          = '0;
                    table_d        = build_table(bus.act, wbits_eff == CNT_WIDTH'(1));
                    table_update_d = 1'b1;
                    state_d        = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (plane_fire) begin
                    lut_weights_d = bus.wplane;
                    pend_d        = 1'b1;
                    shift_d       = cnt_q[SHIFT_WIDTH-1:0];
                    // Top plane of a two's-complement weight carries negative weight.
                    neg_d         = !mode_q && (cnt_q == wbits_q - CNT_WIDTH'(1));
                    cnt_d         = cnt_q + CNT_WIDTH'(1);
                    if (cnt_d == wbits_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_fire) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        start_ready_d  = (state_d == S_IDLE);
        wplane_ready_d = (state_d == S_STREAM) && (cnt_d < wbits_d);
        out_valid_d    = (state_d == S_OUT);
    end

    assign bus.start_ready       = start_ready_q;
    assign bus.wplane_ready      = wplane_ready_q;
    assign bus.lut_mode          = mode_q;
    assign bus.lut_table_update  = table_update_q;
    assign bus.lut_update_values = table_q;
    assign bus.lut_weights       = lut_weights_q;
    assign bus.lut_weights_1b    = ones_q;
    assign bus.acc_out           = acc_q;
    assign bus.out_valid         = out_valid_q;
endmodule
